md5_hash_op: RTL and testbench
==============================

# md5_hash_op

Single-step MD5 compression stage: one of the 64 operations of the MD5 round function, applied to a fixed-length 19-character (152-bit) message. Each pipeline position instantiates this block with its own step index, shift amount and additive constant. Sixty-four instances chained a→a_out form the fully unrolled MD5 hash pipeline. The block is one registered stage with a clock-enable stall.

## Interface
Parameters:
- index, 0: step number 0..63. Selects the round function and the message-word index g.
- s, 7: left-rotate amount, 1..31.
- k, 32'hd76aa478: 32-bit additive constant for this step.
- msg_pad, 360'h80_00…00_98000000_00000000: fixed padding (45 bytes) that follows the message.
  - Byte 0 is 0x80, byte 37 is 0x98 (152-bit length, little-endian); all other bytes are 0.

Ports:
- clk_12mhz  in  1  clock. Reset is `reset`, synchronous, active-high; clock is `clk_12mhz`.
- reset  in  1  synchronous active-high reset.
- en  in  1  clock enable. 0 stalls the stage.
- a, b, c, d  in  32 each  incoming MD5 state.
- m_in  in  152  message bytes 0..18; byte 0 is m_in[151:144].
- valid_in  in  1  marks the inputs as valid this cycle.
- a_out, b_out, c_out, d_out  out  32 each  registered next state.
- valid_out  out  1  registered valid.

## Operation
- Block B[511:0] = {m_in, msg_pad}; byte n is B[511-8n -: 8].
- Message word M[j] = {byte 4j+3, byte 4j+2, byte 4j+1, byte 4j} (little-endian), j = 0..15.
- Round function and word index, selected at elaboration from index:
  - 0–15: F = (b&c)|(~b&d), g = index.
  - 16–31: F = (d&b)|(~d&c), g = (5·index+1) mod 16.
  - 32–47: F = b^c^d, g = (3·index+5) mod 16.
  - 48–63: F = c^(b|~d), g = (7·index) mod 16.
- Step computation:
  - t = a + F + k + M[g], mod 2^32.
  - Register update: a_out ← d, b_out ← b + rotl32(t, s), c_out ← b, d_out ← c.
  - All additions wrap at 32 bits; carries are discarded.
- When en=1, data registers load on every edge regardless of valid_in, and valid_out ← valid_in.
- When en=0, all output registers hold, including valid_out.
- Data outputs are don't-care while valid_out=0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N with en=1 appear on the outputs after edge N.
- One new operation per cycle; back-to-back valid_in is fully supported with no bubbles.
- Reset has priority over en. It clears a_out..d_out to 0 and valid_out to 0 at the next edge.
- Reset asserted mid-operation discards any in-flight result; valid_out is low in the cycle after the reset edge.
- An en=0 cycle that coincides with valid_in=1 drops that input; the bench must hold inputs across stalls.
- All logic is combinational from inputs to registers. Critical path: F → 3-operand add → rotate → add.

## Structure
- Shared package md5_pkg holds:
  - MSG_PAD_19 constant.
  - K[0:63] and S[0:63] tables.
  - word-select function g(index).
  - byte-swap function for M[j].
- Optional sub-module md5_round_func (b, c, d, index → F). Keep the rotate and adders inline.

## Test plan
- Step 0: index=0, s=7, k=d76aa478, a/b/c/d=67452301/efcdab89/98badcfe/10325476, m_in="The quick brown fox", valid_in pulsed one cycle with en=1 → one cycle later valid_out=1 and a/b/c/d_out = 10325476/d7d41184/efcdab89/98badcfe.
- Step 32: index=32, s=4, k=fffa3942, all inputs 0, same m_in (g=5, M[5]=0) → b_out=ffa3942f; a_out, c_out, d_out = 0.
- Step 48: index=48, s=6, k=f4292244, a/b/c/d=0 (F=ffffffff, M[0]=20656854) → b_out=23a2a5c5; others 0.
- Stall: en=0 while valid_in pulses → valid_out stays 0 and outputs unchanged. Then en=1 with valid_in=1 → valid_out next cycle.
- Reset: assert reset in the cycle after valid_in with en=1 → all outputs 0 and valid_out=0 after the reset edge. Post-reset operation matches the step-0 vector.
- Throughput: valid_in high three consecutive cycles with distinct a inputs → three consecutive valid_out cycles, each result correct.

Source files
------------

// File: rtl/md5_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | md5_pkg : shared MD5 constants, step tables and helper functions          |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
package md5_pkg;

   typedef enum logic [1:0] {
      RND_F = 2'd0,
      RND_G = 2'd1,
      RND_H = 2'd2,
      RND_I = 2'd3
   } md5_round_e;

   // 19-byte message: 0x80 marker, zero fill, then the 152-bit length at byte 56 of the block
   localparam logic [359:0] MSG_PAD_19 = {8'h80, 288'h0, 8'h98, 56'h0};

   localparam logic [31:0] K [0:63] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   localparam int unsigned S [0:63] = '{
      7, 12, 17, 22,  7, 12, 17, 22,  7, 12, 17, 22,  7, 12, 17, 22,
      5,  9, 14, 20,  5,  9, 14, 20,  5,  9, 14, 20,  5,  9, 14, 20,
      4, 11, 16, 23,  4, 11, 16, 23,  4, 11, 16, 23,  4, 11, 16, 23,
      6, 10, 15, 21,  6, 10, 15, 21,  6, 10, 15, 21,  6, 10, 15, 21
   };

   function automatic md5_round_e md5_round(input int unsigned idx);
      if (idx < 16)      return RND_F;
      else if (idx < 32) return RND_G;
      else if (idx < 48) return RND_H;
      else               return RND_I;
   endfunction

   function automatic int unsigned md5_g(input int unsigned idx);
      if (idx < 16)      return idx;
      else if (idx < 32) return (5 * idx + 1) % 16;
      else if (idx < 48) return (3 * idx + 5) % 16;
      else               return (7 * idx) % 16;
   endfunction

   function automatic logic [31:0] md5_bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/md5_round_func.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | md5_round_func : MD5 round function F/G/H/I chosen at elaboration         |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module md5_round_func
   import md5_pkg::*;
#(
   parameter int unsigned index = 0
) (
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] f_o
);

   localparam md5_round_e RND = md5_round(index);

   generate
      if (RND == RND_F) begin : g_rnd_f
         assign f_o = (b_i & c_i) | (~b_i & d_i);
      end else if (RND == RND_G) begin : g_rnd_g
         assign f_o = (d_i & b_i) | (~d_i & c_i);
      end else if (RND == RND_H) begin : g_rnd_h
         assign f_o = b_i ^ c_i ^ d_i;
      end else begin : g_rnd_i
         assign f_o = c_i ^ (b_i | ~d_i);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/md5_hash_op.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | md5_hash_op : one registered MD5 compression step with clock-enable stall |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module md5_hash_op
   import md5_pkg::*;
#(
   parameter int unsigned    index   = 0,
   parameter int unsigned    s       = 7,
   parameter logic [31:0]    k       = 32'hd76aa478,
   parameter logic [359:0]   msg_pad = MSG_PAD_19
) (
   input  logic           clk_12mhz,
   input  logic           reset,
   input  logic           en,
   input  logic [31:0]    a,
   input  logic [31:0]    b,
   input  logic [31:0]    c,
   input  logic [31:0]    d,
   input  logic [151:0]   m_in,
   input  logic           valid_in,
   output logic [31:0]    a_out,
   output logic [31:0]    b_out,
   output logic [31:0]    c_out,
   output logic [31:0]    d_out,
   output logic           valid_out
);

   localparam int unsigned G_IDX = md5_g(index);
   localparam int unsigned S_REV = 32 - s;

   logic [511:0] w_block;
   logic [31:0]  w_word;
   logic [31:0]  w_f;
   logic [31:0]  w_t;
   logic [31:0]  w_rot;
   logic         w_unused_block;

   logic [31:0]  a_q, b_q, c_q, d_q;
   logic [31:0]  a_d, b_d, c_d, d_d;
   logic         valid_q;

   assign w_block = {m_in, msg_pad};
   // Only one message word feeds this step; the rest of the block is intentionally dropped
   assign w_unused_block = ^w_block;
   assign w_word = md5_bswap(w_block[511 - 32 * G_IDX -: 32]);

   md5_round_func #(
      .index (index)
   ) u_round_func (
      .b_i (b),
      .c_i (c),
      .d_i (d),
      .f_o (w_f)
   );

   assign w_t   = a + w_f + k + w_word;
   assign w_rot = (w_t << s) | (w_t >> S_REV);

   always_comb begin
      a_d = d;
      b_d = b + w_rot;
      c_d = b;
      d_d = c;
   end

   always_ff @(posedge clk_12mhz) begin
      if (reset) begin
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         c_q     <= 32'h0;
         d_q     <= 32'h0;
         valid_q <= 1'b0;
      end else if (en) begin
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         valid_q <= valid_in;
      end
   end

   assign a_out     = a_q;
   assign b_out     = b_q;
   assign c_out     = c_q;
   assign d_out     = d_q;
   assign valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_md5_hash_op.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_md5_hash_op : four step instances (one per round) against a model      |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module tb_md5_hash_op;

   localparam int          NI = 4;
   localparam int          P_IDX [NI] = '{0, 17, 32, 48};
   localparam int          P_S   [NI] = '{7, 9, 4, 6};
   localparam logic [31:0] P_K   [NI] = '{32'hd76aa478, 32'hc040b340, 32'hfffa3942, 32'hf4292244};

   logic         clk_12mhz = 1'b0;
   logic         reset;
   logic         en;
   logic [31:0]  a, b, c, d;
   logic [151:0] m_in;
   logic         valid_in;

   logic [31:0]  ao [NI];
   logic [31:0]  bo [NI];
   logic [31:0]  co [NI];
   logic [31:0]  dout [NI];
   logic         vo [NI];

   logic [31:0]  exp_st [NI][4];
   logic         exp_v  [NI];

   int           total = 0;
   int           bad   = 0;
   bit           chk_on = 1'b0;

   always #5 clk_12mhz = ~clk_12mhz;

   md5_hash_op #(.index(0), .s(7), .k(32'hd76aa478)) u_s0 (
      .clk_12mhz(clk_12mhz), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d),
      .m_in(m_in), .valid_in(valid_in), .a_out(ao[0]), .b_out(bo[0]), .c_out(co[0]),
      .d_out(dout[0]), .valid_out(vo[0]));
   md5_hash_op #(.index(17), .s(9), .k(32'hc040b340)) u_s17 (
      .clk_12mhz(clk_12mhz), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d),
      .m_in(m_in), .valid_in(valid_in), .a_out(ao[1]), .b_out(bo[1]), .c_out(co[1]),
      .d_out(dout[1]), .valid_out(vo[1]));
   md5_hash_op #(.index(32), .s(4), .k(32'hfffa3942)) u_s32 (
      .clk_12mhz(clk_12mhz), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d),
      .m_in(m_in), .valid_in(valid_in), .a_out(ao[2]), .b_out(bo[2]), .c_out(co[2]),
      .d_out(dout[2]), .valid_out(vo[2]));
   md5_hash_op #(.index(48), .s(6), .k(32'hf4292244)) u_s48 (
      .clk_12mhz(clk_12mhz), .reset(reset), .en(en), .a(a), .b(b), .c(c), .d(d),
      .m_in(m_in), .valid_in(valid_in), .a_out(ao[3]), .b_out(bo[3]), .c_out(co[3]),
      .d_out(dout[3]), .valid_out(vo[3]));

   // New b for one MD5 step, built from a padded 64-byte block
   function automatic logic [31:0] model_b(input int idx, input int sh, input logic [31:0] kk,
                                           input logic [31:0] ma, input logic [31:0] mb,
                                           input logic [31:0] mc, input logic [31:0] md,
                                           input logic [151:0] msg);
      logic [7:0]  blk [64];
      logic [31:0] f, w, t, r;
      int          g;
      for (int i = 0; i < 64; i++) blk[i] = 8'h00;
      for (int i = 0; i < 19; i++) blk[i] = msg[151 - 8 * i -: 8];
      blk[19] = 8'h80;
      blk[56] = 8'h98;
      case (idx / 16)
         0:       begin f = (mb & mc) | (~mb & md); g = idx;                 end
         1:       begin f = (md & mb) | (~md & mc); g = (5 * idx + 1) % 16;  end
         2:       begin f = mb ^ mc ^ md;           g = (3 * idx + 5) % 16;  end
         default: begin f = mc ^ (mb | ~md);        g = (7 * idx) % 16;      end
      endcase
      w = {blk[4 * g + 3], blk[4 * g + 2], blk[4 * g + 1], blk[4 * g]};
      t = ma + f + kk + w;
      r = (t << sh) | (t >> (32 - sh));
      return mb + r;
   endfunction

   always @(posedge clk_12mhz) begin
      for (int n = 0; n < NI; n++) begin
         if (reset) begin
            exp_v[n] <= 1'b0;
            for (int j = 0; j < 4; j++) exp_st[n][j] <= 32'h0;
         end else if (en) begin
            exp_v[n]     <= valid_in;
            exp_st[n][0] <= d;
            exp_st[n][1] <= model_b(P_IDX[n], P_S[n], P_K[n], a, b, c, d, m_in);
            exp_st[n][2] <= b;
            exp_st[n][3] <= c;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk_12mhz) begin
      if (chk_on) begin
         for (int n = 0; n < NI; n++) begin
            chk($sformatf("cyc_valid[%0d]", n), {31'h0, vo[n]}, {31'h0, exp_v[n]});
            if (exp_v[n]) begin
               chk($sformatf("cyc_a[%0d]", n), ao[n],   exp_st[n][0]);
               chk($sformatf("cyc_b[%0d]", n), bo[n],   exp_st[n][1]);
               chk($sformatf("cyc_c[%0d]", n), co[n],   exp_st[n][2]);
               chk($sformatf("cyc_d[%0d]", n), dout[n], exp_st[n][3]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_12mhz);
      #1;
   endtask

   task automatic drive_iv();
      a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
      m_in = "The quick brown fox";
   endtask

   task automatic check_step0(input string tag);
      chk({tag, "_v"}, {31'h0, vo[0]}, 32'h1);
      chk({tag, "_a"}, ao[0],   32'h10325476);
      chk({tag, "_b"}, bo[0],   32'hd7d41184);
      chk({tag, "_c"}, co[0],   32'hefcdab89);
      chk({tag, "_d"}, dout[0], 32'h98badcfe);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; valid_in = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      m_in = "The quick brown fox";
      repeat (3) step();
      chk_on = 1'b1;
      for (int n = 0; n < NI; n++) begin
         chk("rst_valid", {31'h0, vo[n]}, 32'h0);
         chk("rst_b", bo[n], 32'h0);
      end
      reset = 1'b0;

      // step 0 reference vector
      en = 1'b1; valid_in = 1'b1; drive_iv();
      step();
      check_step0("step0");
      chk("model_b0", exp_st[0][1], 32'hd7d41184);

      // all-zero state: steps 32 and 48
      a = '0; b = '0; c = '0; d = '0;
      step();
      chk("step32_b", bo[2], 32'hffa3942f);
      chk("step32_a", ao[2], 32'h0);
      chk("step32_c", co[2], 32'h0);
      chk("step32_d", dout[2], 32'h0);
      chk("step48_b", bo[3], 32'h23a2a5c5);
      chk("model_b48", exp_st[3][1], 32'h23a2a5c5);
      valid_in = 1'b0;
      step();

      // stall drops the valid input
      en = 1'b0; valid_in = 1'b1; a = 32'h13579bdf;
      step(); step();
      chk("stall_valid", {31'h0, vo[0]}, 32'h0);
      en = 1'b1;
      step();
      chk("unstall_valid", {31'h0, vo[0]}, 32'h1);
      valid_in = 1'b0;
      step();

      // reset discards an in-flight result
      drive_iv(); valid_in = 1'b1;
      step();
      reset = 1'b1; valid_in = 1'b0;
      step();
      chk("midrst_valid", {31'h0, vo[0]}, 32'h0);
      chk("midrst_b", bo[0], 32'h0);
      chk("midrst_a", ao[0], 32'h0);
      reset = 1'b0; drive_iv(); valid_in = 1'b1;
      step();
      check_step0("postrst");

      // back-to-back throughput
      for (int i = 0; i < 3; i++) begin
         a = 32'h1000_0000 * (i + 1) + $urandom_range(0, 255);
         step();
         chk("thru_valid", {31'h0, vo[0]}, 32'h1);
      end
      valid_in = 1'b0;
      step();
      chk("thru_end_valid", {31'h0, vo[0]}, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 49) == 0);
         en       = ($urandom_range(0, 3) != 0);
         valid_in = $urandom_range(0, 1) == 1;
         a = $urandom; b = $urandom; c = $urandom; d = $urandom;
         m_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
         step();
      end
      reset = 1'b0; en = 1'b1; valid_in = 1'b0;
      step();
      @(negedge clk_12mhz);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
